// File: rtl/nonlinear_stream_unit_pkg.sv
// Shared parameters for the nonlinear stream unit: defaults, mode and FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nonlinear_stream_unit_pkg;

    localparam int N_LANES_DEF  = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 15;
    localparam int LUT_ADDR_DEF = 6;

    typedef logic [1:0] mode_t;
    localparam mode_t MODE_BYPASS = 2'd0;
    localparam mode_t MODE_RELU   = 2'd1;
    localparam mode_t MODE_LUT    = 2'd2;
    localparam mode_t MODE_SHIFT  = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int lut_size(input int lut_addr_w);
        return 1 << lut_addr_w;
    endfunction

endpackage

// File: rtl/nl_lane_op.sv
// Per-lane nonlinear datapath: bypass, ReLU, LUT lookup or arithmetic right shift.
// Latency: purely combinational.
// Backpressure: none; the LUT image is shared and each lane reads it independently.
// Ports: mode_i/shift_i select the op, x_i is the signed lane, lut_i the flattened LUT, y_o the result.
module nl_lane_op
    import nonlinear_stream_unit_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LUT_ADDR = LUT_ADDR_DEF
) (
    input  mode_t                                    mode_i,
    input  logic [3:0]                               shift_i,
    input  logic signed [DATA_W-1:0]                 x_i,
    input  logic [lut_size(LUT_ADDR)*DATA_W-1:0]     lut_i,
    output logic [DATA_W-1:0]                        y_o
);

    localparam int LUT_SIZE = lut_size(LUT_ADDR);
    localparam logic signed [DATA_W+1:0] IDX_MID = (DATA_W+2)'(LUT_SIZE / 2);
    localparam logic signed [DATA_W+1:0] IDX_MAX = (DATA_W+2)'(LUT_SIZE - 1);

    logic signed [DATA_W+1:0] x_ext;
    logic signed [DATA_W+1:0] x_sh;
    logic signed [DATA_W+1:0] idx_sum;
    logic [LUT_ADDR-1:0]      idx;

    always_comb begin
        // Two guard bits keep the centring offset from wrapping before the clamp.
        x_ext   = {{2{x_i[DATA_W-1]}}, x_i};
        x_sh    = x_ext >>> shift_i;
        idx_sum = x_sh + IDX_MID;
        if (idx_sum[DATA_W+1]) begin
            idx = '0;
        end else if (idx_sum > IDX_MAX) begin
            idx = '1;
        end else begin
            idx = idx_sum[LUT_ADDR-1:0];
        end

        case (mode_i)
            MODE_RELU:  y_o = x_i[DATA_W-1] ? '0 : x_i;
            MODE_LUT:   y_o = lut_i[idx*DATA_W +: DATA_W];
            MODE_SHIFT: y_o = x_i >>> shift_i;
            default:    y_o = x_i;
        endcase
    end

endmodule

// File: rtl/nonlinear_stream_unit.sv
// Streams num_words words from activation memory through a per-lane nonlinear op and writes them back.
// Latency: wr_en follows its rd_en by exactly 2 cycles; 1 word/cycle sustained; done 1 cycle after last write.
// Backpressure: none; memory must accept 1 read and 1 write per cycle. LUT writes while busy are dropped and flagged.
// Ports: job control (start/mode/shift/num_words/bases), LUT load port, memory read/write ports, busy/done/lut_wr_err status.
module nonlinear_stream_unit
    import nonlinear_stream_unit_pkg::*;
#(
    parameter int N_LANES  = N_LANES_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LUT_ADDR = LUT_ADDR_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [3:0]                  shift,
    input  logic [31:0]                 num_words,
    input  logic [ADDR_W-1:0]           rd_base,
    input  logic [ADDR_W-1:0]           wr_base,
    input  logic                        lut_wr_en,
    input  logic [LUT_ADDR-1:0]         lut_wr_addr,
    input  logic [DATA_W-1:0]           lut_wr_data,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [N_LANES*DATA_W-1:0]   read_word,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [N_LANES*DATA_W-1:0]   output_word,
    output logic                        busy,
    output logic                        done,
    output logic                        lut_wr_err
);

    localparam int LUT_SIZE = lut_size(LUT_ADDR);
    localparam int WORD_W   = N_LANES * DATA_W;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [3:0]          shift_q, shift_d;
    logic [31:0]         rem_q, rem_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                rd_vld_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [WORD_W-1:0]   out_q;
    logic [WORD_W-1:0]   result;
    logic                lut_err_q;
    logic [LUT_SIZE*DATA_W-1:0] lut_q;

    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign rd_en       = (state_q == ST_RUN);
    assign rd_addr     = rd_en ? rd_ptr_q : '0;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign output_word = out_q;
    assign lut_wr_err  = lut_err_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        shift_d  = shift_q;
        rem_d    = rem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = rd_vld_q ? wr_ptr_q + 1'b1 : wr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    shift_d  = shift;
                    rem_d    = num_words;
                    rd_ptr_d = rd_base;
                    wr_ptr_d = wr_base;
                    state_d  = (num_words == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rem_d    = rem_q - 32'd1;
                if (rem_q == 32'd1) begin
                    state_d = ST_DRAIN;
                end
            end
            // Last write is on the bus when nothing is left in the read-data stage.
            ST_DRAIN: begin
                if (wr_en_q && !rd_vld_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        nl_lane_op #(
            .DATA_W   (DATA_W),
            .LUT_ADDR (LUT_ADDR)
        ) u_lane_op (
            .mode_i  (mode_q),
            .shift_i (shift_q),
            .x_i     (read_word[g*DATA_W +: DATA_W]),
            .lut_i   (lut_q),
            .y_o     (result[g*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_BYPASS;
            shift_q   <= '0;
            rem_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_vld_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            out_q     <= '0;
            lut_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            rem_q     <= rem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            // rd_vld_q marks the cycle read_word carries the data for last cycle's read.
            rd_vld_q  <= rd_en;
            wr_en_q   <= rd_vld_q;
            wr_addr_q <= rd_vld_q ? wr_ptr_q : '0;
            out_q     <= rd_vld_q ? result : '0;
            lut_err_q <= lut_wr_en && busy;
        end
    end

    // LUT contents survive reset so a reloaded table is not needed after an abort.
    always_ff @(posedge clk) begin
        if (lut_wr_en && !busy) begin
            lut_q[lut_wr_addr*DATA_W +: DATA_W] <= lut_wr_data;
        end
    end

endmodule

// File: tb/tb_nonlinear_stream_unit.sv
module tb_nonlinear_stream_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [3:0]  shift = '0;
    logic [31:0] num_words = '0;
    logic [14:0] rd_base = '0;
    logic [14:0] wr_base = '0;
    logic        lut_wr_en = 1'b0;
    logic [5:0]  lut_wr_addr = '0;
    logic [7:0]  lut_wr_data = '0;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [31:0] read_word = '0;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [31:0] output_word;
    logic        busy;
    logic        done;
    logic        lut_wr_err;

    nonlinear_stream_unit dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .shift(shift),
        .num_words(num_words), .rd_base(rd_base), .wr_base(wr_base),
        .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .read_word(read_word),
        .wr_en(wr_en), .wr_addr(wr_addr), .output_word(output_word),
        .busy(busy), .done(done), .lut_wr_err(lut_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rel;
        int          addr;
        logic [31:0] dat;
    } ev_t;

    logic [31:0] mem [0:32767];
    int          lut_m [64];
    ev_t         rdq[$];
    ev_t         wrq[$];
    int          cyc = 0;
    int          start_cyc = 0;
    int          n_done = 0;
    int          done_rel = -1;
    int          idle_viol = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural per-lane reference using plain integer arithmetic.
    function automatic logic [31:0] model_word(input logic [1:0] m, input logic [3:0] sh, input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int x;
            int y;
            int t;
            x = $signed(w[i*8 +: 8]);
            case (m)
                2'd0: y = x;
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: begin
                    t = (x >>> sh) + 32;
                    if (t < 0) t = 0;
                    if (t > 63) t = 63;
                    y = lut_m[t];
                end
                default: y = x >>> sh;
            endcase
            r[i*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        ev_t e;
        if (rd_en) begin
            e.rel = cyc - start_cyc; e.addr = int'(rd_addr); e.dat = '0;
            rdq.push_back(e);
        end else if (rd_addr != '0) idle_viol++;
        if (wr_en) begin
            e.rel = cyc - start_cyc; e.addr = int'(wr_addr); e.dat = output_word;
            wrq.push_back(e);
        end else if (wr_addr != '0 || output_word != '0) idle_viol++;
        if (done) begin
            n_done++;
            done_rel = cyc - start_cyc;
        end
    end

    // Memory responder: data for a read appears in the following cycle.
    initial begin
        logic        seen;
        logic [14:0] a;
        forever begin
            @(negedge clk);
            seen = rd_en;
            a    = rd_addr;
            @(posedge clk);
            #1;
            read_word = seen ? mem[a] : 32'h0;
        end
    end

    task automatic lut_write(input int idx, input int val);
        @(posedge clk); #1;
        lut_wr_en = 1'b1; lut_wr_addr = 6'(idx); lut_wr_data = 8'(val);
        lut_m[idx] = $signed(8'(val));
        @(posedge clk); #1;
        lut_wr_en = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] m, input logic [3:0] sh, input int nw, input int rb, input int wb);
        int budget;
        int exp_done;
        rdq.delete(); wrq.delete(); n_done = 0; done_rel = -1;
        @(posedge clk); #1;
        mode = m; shift = sh; num_words = nw; rd_base = 15'(rb); wr_base = 15'(wb);
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble job inputs so the unit must rely on its latched copies.
        mode = 2'($urandom); shift = 4'($urandom); num_words = $urandom_range(1, 50);
        rd_base = 15'($urandom); wr_base = 15'($urandom);
        budget = 0;
        while (n_done == 0 && budget < nw + 20) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        exp_done = (nw == 0) ? 1 : nw + 3;
        check("done_count", n_done, 1);
        check("done_cycle", done_rel, exp_done);
        check("rd_count", rdq.size(), nw);
        check("wr_count", wrq.size(), nw);
        for (int k = 0; k < nw && k < rdq.size(); k++) begin
            check("rd_cycle", rdq[k].rel, k + 1);
            check("rd_addr", rdq[k].addr, (rb + k) % 32768);
        end
        for (int k = 0; k < nw && k < wrq.size(); k++) begin
            check("wr_cycle", wrq[k].rel, k + 3);
            check("wr_addr", wrq[k].addr, (wb + k) % 32768);
            check("wr_data", wrq[k].dat, model_word(m, sh, mem[(rb + k) % 32768]));
        end
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 32768; i++) mem[i] = $urandom;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lut_err", lut_wr_err, 0);
        check("rst_addrs", {rd_addr, wr_addr}, 0);
        check("rst_word", output_word, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 64; i++) lut_write(i, i - 32);

        // LUT ramp, mode 2: clamp at the low end and midpoint mapping.
        mem[16] = 32'h7F800005;
        run_job(2'd2, 4'd0, 4, 16'h10, 16'h20);
        if (wrq.size() > 0) check("lut_word0", wrq[0].dat, 32'h1FE00005);

        mem[16'h40] = 32'h7F8001FF;
        run_job(2'd1, 4'd0, 1, 16'h40, 16'h50);
        if (wrq.size() > 0) check("relu_word", wrq[0].dat, 32'h7F000100);

        mem[16'h60] = 32'h00000081;
        run_job(2'd3, 4'd2, 1, 16'h60, 16'h70);
        if (wrq.size() > 0) check("shift_word", wrq[0].dat, 32'h000000E0);

        run_job(2'd0, 4'd0, 0, 16'h80, 16'h90);

        run_job(2'd0, 4'd0, 3, 16'h7FFE, 16'h7FF0);
        if (rdq.size() > 2) check("rd_wrap", rdq[2].addr, 0);

        // LUT write and a stray start while busy must both be ignored.
        fork
            run_job(2'd1, 4'd0, 8, 16'h300, 16'h380);
            begin
                repeat (3) @(posedge clk); #1;
                lut_wr_en = 1'b1; lut_wr_addr = 6'd5; lut_wr_data = 8'h55;
                start = 1'b1; rd_base = 15'h0;
                @(posedge clk); #1;
                lut_wr_en = 1'b0; start = 1'b0;
                @(negedge clk);
                check("lut_err_pulse", lut_wr_err, 1);
                @(negedge clk);
                check("lut_err_single", lut_wr_err, 0);
            end
        join
        mem[16'h400] = 32'h000000E5;
        run_job(2'd2, 4'd0, 1, 16'h400, 16'h410);
        if (wrq.size() > 0) check("lut_entry_kept", wrq[0].dat, 32'h000000E5);

        for (int j = 0; j < 8; j++) begin
            if (j == 3) for (int i = 0; i < 64; i++) lut_write(i, $urandom_range(0, 255));
            run_job(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(1, 12),
                    (j == 5) ? 32760 : $urandom_range(0, 32767), $urandom_range(0, 32767));
        end

        // Abort mid-job: reset while the third write is on the bus.
        rdq.delete(); wrq.delete(); n_done = 0;
        @(posedge clk); #1;
        mode = 2'd0; shift = 4'd0; num_words = 8; rd_base = 15'h100; wr_base = 15'h200;
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (wrq.size() < 2 && budget < 30) begin
            @(posedge clk);
            budget++;
        end
        check("abort_pre_writes", wrq.size(), 2);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_wr_low", wr_en, 0);
        check("abort_busy_low", busy, 0);
        repeat (15) @(negedge clk);
        check("abort_total_writes", wrq.size(), 3);
        check("abort_no_done", n_done, 0);

        check("idle_outputs_zero", idle_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nonlinear_stream_unit.md
NONLINEAR_STREAM_UNIT -- requirements
Module: nonlinear_stream_unit

Interface
REQ-001 SHALL have parameter N_LANES, default 4, giving the number of lanes per memory word.
REQ-002 SHALL have parameter DATA_W, default 8, giving the signed lane width.
REQ-003 SHALL have parameter ADDR_W, default 15, giving the activation memory address width.
REQ-004 SHALL have parameter LUT_ADDR, default 6, giving the LUT index width; LUT_SIZE = 2^LUT_ADDR.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle job launch
- mode  in  2  0 bypass, 1 ReLU, 2 LUT (sigmoid/tanh), 3 saturating right shift
- shift  in  4  fixed-point shift amount
- num_words  in  32  words to process
- rd_base  in  ADDR_W  first read address
- wr_base  in  ADDR_W  first write address
- lut_wr_en  in  1  LUT load strobe
- lut_wr_addr  in  LUT_ADDR  LUT load index
- lut_wr_data  in  DATA_W  signed LUT entry
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- read_word  in  N_LANES*DATA_W  read data, valid 1 cycle after rd_en
- wr_en  out  1  result write strobe
- wr_addr  out  ADDR_W  result write address
- output_word  out  N_LANES*DATA_W  result data
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- lut_wr_err  out  1  one-cycle pulse when a LUT write is rejected

Function
REQ-006 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-007 SHALL, on start in IDLE, latch mode, shift, num_words, rd_base and wr_base, then enter RUN, or enter DONE if num_words==0.
REQ-008 SHALL ignore start outside IDLE.
REQ-009 SHALL, in RUN, assert rd_en every cycle with rd_addr = rd_base+k for k = 0..num_words-1, then enter DRAIN.
REQ-010 SHALL register each result so that wr_en rises exactly 2 cycles after the corresponding rd_en, with wr_addr = wr_base+k, sustaining 1 word/cycle.
REQ-011 SHALL stay in DRAIN until the last wr_en is issued, then enter DONE; DONE SHALL last 1 cycle with done=1 and then return to IDLE.
REQ-012 SHALL hold busy=1 in RUN and DRAIN and 0 otherwise.
REQ-013 SHALL wrap read and write addresses modulo 2^ADDR_W.
REQ-014 SHALL process every lane independently, with lane i at bits [i*DATA_W +: DATA_W].
REQ-015 Mode 0 SHALL copy the lane unchanged.
REQ-016 Mode 1 SHALL output max(x,0).
REQ-017 Mode 2 SHALL output lut[idx] with idx = clamp((x>>>shift) + LUT_SIZE/2, 0, LUT_SIZE-1), computed in DATA_W+2 signed bits.
REQ-018 Mode 3 SHALL output x>>>shift (arithmetic) and never overflow.
REQ-019 SHALL write lut[lut_wr_addr] = lut_wr_data when lut_wr_en=1 and busy=0.
REQ-020 SHALL discard a LUT write when lut_wr_en=1 and busy=1, and pulse lut_wr_err in the following cycle.
REQ-021 SHALL drive rd_en, wr_en, rd_addr, wr_addr and output_word to 0 in any cycle with no access.

Reset
REQ-022 SHALL, on reset, enter IDLE and clear rd_en, wr_en, busy, done, lut_wr_err, rd_addr, wr_addr, output_word and the pipeline valid bits at the next edge.
REQ-023 SHALL abort an in-flight job on reset, issuing no further writes and no done pulse.
REQ-024 SHALL leave LUT contents unchanged on reset.

Structure
REQ-025 SHALL take mode encodings, FSM state typedef, LUT_SIZE and the parameter defaults from the shared parameters package.
REQ-026 SHALL instantiate one sub-module, nl_lane_op, per lane: combinational mode datapath plus LUT read, with the LUT shared and read-replicated across lanes.

Verification
REQ-027 Bench SHALL cover:
- LUT ramp lut[i]=i-32, mode 2, shift 0, num_words=4, rd_base=0x10, wr_base=0x20 -> rd_en at cycles 1-4 (addresses 0x10-0x13), wr_en at cycles 3-6 (addresses 0x20-0x23), lane 0x05 -> 0x05, lane 0x80 -> 0xE0 (clamped to idx 0), done pulse at cycle 7.
- mode 1, word 0x7F80_01FF -> 0x7F00_0100.
- mode 3, shift 2, lane 0x81 -> 0xE0.
- num_words=0 -> no rd_en/wr_en, done 1 cycle after start.
- rd_base=0x7FFE, num_words=3 -> read addresses 0x7FFE, 0x7FFF, 0x0000.
- lut_wr_en during RUN -> entry unchanged, lut_wr_err pulse.
- Reset at word 2 of 8 -> wr_en low next cycle, no done pulse.
